// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared types and constants for the canvas frame store.
//               - RAM slot encoding used by the read/write time-division FSM
//               - Colour codes (off-canvas border, clear/erase colour, ink)
//               - Canvas geometry shared with the VGA timing block
// Revision    : 1.0  initial release
// ============================================================================
package pixel_pkg;

  // The RAM is time-shared: one READ slot for scan-out, then one WRITE slot
  // for the brush/clear path, forever alternating.
  typedef enum logic [0:0] {
    RAM_READ  = 1'b0,
    RAM_WRITE = 1'b1
  } ram_slot_t;

  // Canvas geometry (side = 2^CANVAS_COORD_W) and VGA scan coordinate width.
  localparam int CANVAS_COORD_W = 7;
  localparam int CANVAS_SIDE    = 1 << CANVAS_COORD_W;
  localparam int SCAN_COORD_W   = 10;

  // Colour codes, stored 16 bits wide so any COLOR_W up to 16 can slice them.
  localparam logic [15:0] INK_C     = 16'h0000;  // black ink
  localparam logic [15:0] OUTSIDE_C = 16'h0004;  // border drawn off-canvas
  localparam logic [15:0] ERASE_C   = 16'h0007;  // blank paper after a clear

endpackage
`default_nettype wire

// File: rtl/SP256K.sv
`default_nettype none
// ============================================================================
// Module      : SP256K
// Description : Behavioural model of the iCE40 UltraPlus 16K x 16 single-port
//               SPRAM primitive. Leave out of the synthesis file list; the
//               vendor library supplies the real cell.
// Ports       : AD address, DI write data, MASKWE nibble write enables,
//               WE write enable, CS chip select, CK clock, STDBY/SLEEP/
//               PWROFF_N power controls, DO registered read data.
// Revision    : 1.0  initial release
// ============================================================================
module SP256K (
  input  logic [13:0] AD,
  input  logic [15:0] DI,
  input  logic [3:0]  MASKWE,
  input  logic        WE,
  input  logic        CS,
  input  logic        CK,
  input  logic        STDBY,
  input  logic        SLEEP,
  input  logic        PWROFF_N,
  output logic [15:0] DO
);

  logic [15:0] r_mem [16384];
  logic        w_active;

  assign w_active = CS & ~STDBY & ~SLEEP & PWROFF_N;

  always_ff @(posedge CK) begin
    if (w_active) begin
      if (WE) begin
        for (int i = 0; i < 4; i++) begin
          if (MASKWE[i]) r_mem[AD][4*i +: 4] <= DI[4*i +: 4];
        end
      end else begin
        DO <= r_mem[AD];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_write_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_write_fifo
// Description : Small synchronous FIFO buffering brush writes until a RAM
//               WRITE slot is available. Flush empties it in one edge.
// Ports       : clk, reset (async, active-high)
//               push/push_data : enqueue (ignored when full)
//               pop/pop_data   : dequeue head (pop_data shows head always)
//               flush          : discard all entries (wins over push/pop)
//               full/empty     : occupancy flags
// Revision    : 1.0  initial release
// ============================================================================
module pixel_write_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  input  logic             flush,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == (PTR_W+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_push   = push & ~full;
  assign w_pop    = pop & ~empty;
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/pixel_frame_store.sv
`default_nettype none
// ============================================================================
// Module      : pixel_frame_store
// Description : Canvas frame buffer between the brush write path and the VGA
//               scan-out read path, held in one SP256K SPRAM. The RAM
//               alternates READ/WRITE slots each cycle; brush writes wait in
//               a small FIFO; a hardware sweep can clear the whole canvas.
// Ports       : clk, reset (async, active-high)
//               wr_valid/wr_ready/wr_x/wr_y/wr_color : brush write handshake
//               clear_req (pulse) / clear_busy        : clear-canvas sweep
//               rd_x/rd_y                             : VGA scan coordinate
//               color_code                            : registered pixel colour
//               rd_slot                               : 1 during a READ slot
// Revision    : 1.0  initial release
// ============================================================================
module pixel_frame_store
  import pixel_pkg::*;
#(
  parameter int                 COORD_W  = CANVAS_COORD_W,
  parameter int                 COLOR_W  = 3,
  parameter int                 SCAN_W   = SCAN_COORD_W,
  parameter int                 WQ_DEPTH = 4,
  parameter logic [COLOR_W-1:0] OUTSIDE  = COLOR_W'(OUTSIDE_C),
  parameter logic [COLOR_W-1:0] BLANK    = COLOR_W'(ERASE_C)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               clear_req,
  output logic               clear_busy,
  input  logic [SCAN_W-1:0]  rd_x,
  input  logic [SCAN_W-1:0]  rd_y,
  output logic [COLOR_W-1:0] color_code,
  output logic               rd_slot
);

  localparam int                ADDR_W   = 2 * COORD_W;
  localparam int                ENTRY_W  = ADDR_W + COLOR_W;
  localparam logic [ADDR_W-1:0] CLR_LAST = {ADDR_W{1'b1}};
  localparam logic [SCAN_W:0]   SIDE     = (SCAN_W+1)'(1) << COORD_W;

  ram_slot_t           r_slot;
  ram_slot_t           w_slot_nxt;
  logic                r_clear_busy;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                r_live;
  logic                r_off_canvas;
  logic                w_off_canvas;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_full;
  logic                w_empty;
  logic                w_clr_step;
  logic [ENTRY_W-1:0]  w_head;
  logic [COORD_W-1:0]  w_head_x;
  logic [COORD_W-1:0]  w_head_y;
  logic [COLOR_W-1:0]  w_head_color;
  logic [13:0]         w_ram_ad;
  logic [15:0]         w_ram_di;
  logic                w_ram_we;
  logic [15:0]         w_ram_do;
  logic                w_unused_do;

  // r_live holds wr_ready low until the first edge after reset release.
  assign wr_ready     = r_live & ~w_full & ~r_clear_busy;
  assign clear_busy   = r_clear_busy;
  assign w_push       = wr_valid & wr_ready;
  // A starting clear discards queued paints; the sweep would erase them anyway.
  assign w_flush      = clear_req & ~r_clear_busy;
  assign w_rd_addr    = {rd_y[COORD_W-1:0], rd_x[COORD_W-1:0]};
  assign w_off_canvas = ({1'b0, rd_x} >= SIDE) | ({1'b0, rd_y} >= SIDE);
  assign w_head_x     = w_head[ENTRY_W-1 -: COORD_W];
  assign w_head_y     = w_head[COLOR_W+COORD_W-1 -: COORD_W];
  assign w_head_color = w_head[COLOR_W-1:0];
  assign w_unused_do  = ^w_ram_do;

  // ---------------- slot FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_slot <= RAM_READ;
    else       r_slot <= w_slot_nxt;
  end

  // ---------------- slot FSM: next state ----------------
  always_comb begin
    w_slot_nxt = RAM_READ;
    case (r_slot)
      RAM_READ:  w_slot_nxt = RAM_WRITE;
      RAM_WRITE: w_slot_nxt = RAM_READ;
      default:   w_slot_nxt = RAM_READ;
    endcase
  end

  // ---------------- slot FSM: outputs / RAM port mux ----------------
  always_comb begin
    rd_slot    = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_ad   = 14'(w_rd_addr);
    w_ram_di   = '0;
    w_pop      = 1'b0;
    w_clr_step = 1'b0;
    case (r_slot)
      RAM_READ: rd_slot = 1'b1;
      RAM_WRITE: begin
        // Clear sweep outranks brush writes.
        if (r_clear_busy) begin
          w_ram_ad   = 14'(r_clr_addr);
          w_ram_di   = 16'(BLANK);
          w_ram_we   = 1'b1;
          w_clr_step = 1'b1;
        end else if (!w_empty) begin
          w_ram_ad = 14'({w_head_y, w_head_x});
          w_ram_di = 16'(w_head_color);
          w_ram_we = 1'b1;
          w_pop    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  // Clear sweep: one address per WRITE slot; busy drops as the address wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clear_busy <= 1'b0;
      r_clr_addr   <= '0;
    end else if (!r_clear_busy) begin
      if (clear_req) r_clear_busy <= 1'b1;
    end else if (w_clr_step) begin
      r_clr_addr <= r_clr_addr + ADDR_W'(1);
      if (r_clr_addr == CLR_LAST) r_clear_busy <= 1'b0;
    end
  end

  // The off-canvas decision travels alongside the RAM read so the output
  // register sees both in the WRITE slot, when DO is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_off_canvas <= 1'b0;
      color_code   <= '0;
    end else if (r_slot == RAM_READ) begin
      r_off_canvas <= w_off_canvas;
    end else begin
      color_code <= r_off_canvas ? OUTSIDE : w_ram_do[COLOR_W-1:0];
    end
  end

  pixel_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WQ_DEPTH)
  ) u_write_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data ({wr_x, wr_y, wr_color}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .flush     (w_flush),
    .full      (w_full),
    .empty     (w_empty)
  );

  SP256K u_spram (
    .AD       (w_ram_ad),
    .DI       (w_ram_di),
    .MASKWE   (4'b1111),
    .WE       (w_ram_we),
    .CS       (1'b1),
    .CK       (clk),
    .STDBY    (1'b0),
    .SLEEP    (1'b0),
    .PWROFF_N (1'b1),
    .DO       (w_ram_do)
  );

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_frame_store
// Description : Directed self-checking bench for pixel_frame_store with the
//               default geometry (128x128 canvas, 3-bit colour, OUTSIDE=4,
//               BLANK=7).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_frame_store;

  localparam logic [2:0] OUTSIDE_V = 3'd4;
  localparam logic [2:0] BLANK_V   = 3'd7;
  localparam int         CLR_CYC   = 2 * 16384;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_x;
  logic [6:0] wr_y;
  logic [2:0] wr_color;
  logic       clear_req;
  logic       clear_busy;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic [2:0] color_code;
  logic       rd_slot;

  int checks   = 0;
  int failures = 0;

  pixel_frame_store dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_color   (wr_color),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .color_code (color_code),
    .rd_slot    (rd_slot)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input logic want);
    int g = 0;
    while (rd_slot !== want && g < 4) begin
      tick();
      g++;
    end
  endtask

  task automatic paint(input logic [6:0] x, input logic [6:0] y, input logic [2:0] c);
    int g = 0;
    wr_x = x; wr_y = y; wr_color = c; wr_valid = 1'b1;
    while (!wr_ready && g < 100) begin
      tick();
      g++;
    end
    if (g == 100) check_value("paint_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
  endtask

  // Align to a READ slot, present the coordinate, output is due 2 edges later.
  task automatic read_pix(input logic [9:0] x, input logic [9:0] y, output logic [2:0] c);
    wait_slot(1'b1);
    rd_x = x; rd_y = y;
    tick();
    tick();
    c = color_code;
  endtask

  task automatic expect_pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic [2:0] exp);
    logic [2:0] c;
    read_pix(x, y, c);
    check_value(tag, c, exp);
  endtask

  // Count edges from a WRITE-slot clear request until clear_busy falls.
  task automatic timed_clear(input bit mid_req, output int n);
    wait_slot(1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check_value("clr_busy_start", clear_busy, 1);
    n = 0;
    do begin
      clear_req = mid_req && (n == 1000);
      tick();
      n++;
    end while (clear_busy && n < 40000);
    clear_req = 1'b0;
  endtask

  logic [6:0] bx [8];
  logic [2:0] bc [8];
  int         stalls;
  int         ncyc;

  initial begin
    bx = '{7'd10, 7'd11, 7'd12, 7'd13, 7'd14, 7'd15, 7'd12, 7'd16};
    bc = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
    reset = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clear_req = 1'b0; rd_x = '0; rd_y = '0;

    // ---- reset state ----
    repeat (3) tick();
    check_value("rst_color", color_code, 0);
    check_value("rst_ready", wr_ready, 0);
    check_value("rst_busy", clear_busy, 0);
    check_value("rst_slot", rd_slot, 1);
    reset = 1'b0;
    tick();
    check_value("rel_ready", wr_ready, 1);
    check_value("rel_slot_w", rd_slot, 0);
    check_value("rel_color", color_code, 0);
    tick();
    check_value("rel_slot_r", rd_slot, 1);

    // ---- single write and read latency ----
    paint(7'd6, 7'd9, 3'd5);
    paint(7'd5, 7'd9, 3'd2);
    repeat (8) tick();
    expect_pix("pix_6_9", 10'd6, 10'd9, 3'd5);
    wait_slot(1'b1);
    rd_x = 10'd5; rd_y = 10'd9;
    tick();
    check_value("lat_hold", color_code, 5);
    tick();
    check_value("lat_update", color_code, 2);

    // ---- off-canvas scan coordinates alias onto painted pixels ----
    paint(7'd0, 7'd3, 3'd6);
    paint(7'd3, 7'd72, 3'd1);
    repeat (8) tick();
    expect_pix("pix_0_3", 10'd0, 10'd3, 3'd6);
    expect_pix("off_x128", 10'd128, 10'd3, OUTSIDE_V);
    expect_pix("off_y200", 10'd3, 10'd200, OUTSIDE_V);
    expect_pix("pix_3_72", 10'd3, 10'd72, 3'd1);

    // ---- burst of 8 writes held back-to-back ----
    wait_slot(1'b1);
    stalls = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int g = 0;
      wr_x = bx[i]; wr_y = 7'd20; wr_color = bc[i];
      while (!wr_ready && g < 50) begin
        tick();
        stalls++;
        g++;
      end
      tick();
    end
    wr_valid = 1'b0;
    check_value("burst_stalls", stalls, 1);
    repeat (12) tick();
    check_value("burst_drained_ready", wr_ready, 1);
    expect_pix("burst_10", 10'd10, 10'd20, 3'd1);
    expect_pix("burst_11", 10'd11, 10'd20, 3'd2);
    expect_pix("burst_12_last", 10'd12, 10'd20, 3'd7);
    expect_pix("burst_13", 10'd13, 10'd20, 3'd4);
    expect_pix("burst_14", 10'd14, 10'd20, 3'd5);
    expect_pix("burst_15", 10'd15, 10'd20, 3'd6);
    expect_pix("burst_16", 10'd16, 10'd20, 3'd2);

    // ---- clear with writes still queued, plus a mid-sweep request ----
    wait_slot(1'b0);
    wr_valid = 1'b1;
    wr_x = 7'd30; wr_y = 7'd30; wr_color = 3'd1;
    tick();
    wr_x = 7'd31; wr_color = 3'd2;
    tick();
    wr_x = 7'd32; wr_color = 3'd3; clear_req = 1'b1;
    check_value("clr_push_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0; clear_req = 1'b0;
    check_value("clr_busy_start", clear_busy, 1);
    check_value("clr_ready_low", wr_ready, 0);
    ncyc = 0;
    do begin
      clear_req = (ncyc == 1000);
      tick();
      ncyc++;
    end while (clear_busy && ncyc < 40000);
    clear_req = 1'b0;
    check_value("clr_duration", ncyc, CLR_CYC);
    check_value("clr_done_ready", wr_ready, 1);
    repeat (10) tick();
    expect_pix("clr_q30", 10'd30, 10'd30, BLANK_V);
    expect_pix("clr_q31", 10'd31, 10'd30, BLANK_V);
    expect_pix("clr_q32", 10'd32, 10'd30, BLANK_V);
    expect_pix("clr_5_9", 10'd5, 10'd9, BLANK_V);
    expect_pix("clr_12_20", 10'd12, 10'd20, BLANK_V);
    expect_pix("clr_0_0", 10'd0, 10'd0, BLANK_V);
    expect_pix("clr_127_127", 10'd127, 10'd127, BLANK_V);

    // ---- reset in the middle of a sweep ----
    paint(7'd40, 7'd40, 3'd5);
    repeat (8) tick();
    expect_pix("pre_rst_40", 10'd40, 10'd40, 3'd5);
    wait_slot(1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (500) tick();
    check_value("mid_busy", clear_busy, 1);
    #2 reset = 1'b1;
    #1;
    check_value("arst_busy", clear_busy, 0);
    check_value("arst_ready", wr_ready, 0);
    check_value("arst_slot", rd_slot, 1);
    check_value("arst_color", color_code, 0);
    tick();
    reset = 1'b0;
    tick();
    check_value("arst_rel_ready", wr_ready, 1);
    timed_clear(1'b0, ncyc);
    check_value("clr2_duration", ncyc, CLR_CYC);
    repeat (4) tick();
    expect_pix("clr2_40", 10'd40, 10'd40, BLANK_V);
    expect_pix("clr2_6_9", 10'd6, 10'd9, BLANK_V);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
